// File: rtl/d2_clock_pkg.sv
// rtl/d2_clock_pkg.sv - shared types, digit indices and limits for the D2 clock sequencer
package d2_clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } set_state_t;

    // Kind of strobe burst to issue; a pending slot holds one of these.
    typedef enum logic [2:0] {
        REQ_NONE,
        REQ_TICK,
        REQ_HR,
        REQ_MIN,
        REQ_SEC0
    } req_t;

    localparam int SEC_U = 0;
    localparam int SEC_T = 1;
    localparam int MIN_U = 2;
    localparam int MIN_T = 3;
    localparam int HR_U  = 4;
    localparam int HR_T  = 5;

    localparam logic [3:0] LIM_9 = 4'd9;
    localparam logic [3:0] LIM_5 = 4'd5;
    localparam logic [3:0] LIM_2 = 4'd2;
    localparam logic [3:0] LIM_3 = 4'd3;

    // At or beyond the limit, so unreachable values also wrap to zero.
    function automatic logic at_limit(input logic [3:0] value, input logic [3:0] limit);
        return value >= limit;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - two-flop synchroniser, debounce counter and press-event pulse
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic clock,
    input  logic n_reset,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any sample agreeing with the accepted level restarts the stability count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/time_sequencer.sv
// rtl/time_sequencer.sv - 1 Hz time base, HH:MM:SS carry decode and two-button set mode
module time_sequencer
    import d2_clock_pkg::*;
#(
    parameter int CLK_HZ          = 32768,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        n_reset,
    input  logic [23:0] digits,
    input  logic        mode_btn,
    input  logic        adv_btn,
    output logic [5:0]  increment,
    output logic [5:0]  zero,
    output logic        second,
    output logic [1:0]  set_state
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    set_state_t    state_q, state_d;
    req_t          pend_q, pend_d;
    req_t          req, issue;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    inc_q, inc_d;
    logic [5:0]    zero_q, zero_d;
    logic          sec_q, sec_d;
    logic          mode_ev, adv_ev;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clock   (clock),
        .n_reset (n_reset),
        .btn_i   (mode_btn),
        .press_o (mode_ev)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_adv_db (
        .clock   (clock),
        .n_reset (n_reset),
        .btn_i   (adv_btn),
        .press_o (adv_ev)
    );

    // Mode always beats adv; the tick still fires when mode arrives in RUN.
    always_comb begin
        state_d = state_q;
        presc_d = '0;
        req     = REQ_NONE;
        case (state_q)
            RUN: begin
                presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
                if (presc_q == PRESC_MAX) req = REQ_TICK;
                if (mode_ev) begin
                    state_d = SET_HR;
                    presc_d = '0;
                end
            end
            SET_HR: begin
                if (mode_ev)     state_d = SET_MIN;
                else if (adv_ev) req = REQ_HR;
            end
            SET_MIN: begin
                if (mode_ev) begin
                    state_d = RUN;
                    req     = REQ_SEC0;
                end else if (adv_ev) begin
                    req = REQ_MIN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // While strobes are out, digits are stale; defer new work by one cycle.
    always_comb begin
        issue  = REQ_NONE;
        pend_d = pend_q;
        if (|inc_q) begin
            if (pend_q == REQ_NONE) pend_d = req;
        end else if (pend_q != REQ_NONE) begin
            issue  = pend_q;
            pend_d = req;
        end else begin
            issue = req;
        end
    end

    logic [3:0] su, st, mu, mt, hu, ht;
    logic       su_l, st_l, mu_l, mt_l, hu_l, ht_l, hr_wrap;
    logic       sec_go, min_go, hr_go;
    logic [5:0] zero_raw;

    always_comb begin
        su      = digits[SEC_U*4 +: 4];
        st      = digits[SEC_T*4 +: 4];
        mu      = digits[MIN_U*4 +: 4];
        mt      = digits[MIN_T*4 +: 4];
        hu      = digits[HR_U*4 +: 4];
        ht      = digits[HR_T*4 +: 4];
        su_l    = at_limit(su, LIM_9);
        st_l    = at_limit(st, LIM_5);
        mu_l    = at_limit(mu, LIM_9);
        mt_l    = at_limit(mt, LIM_5);
        hu_l    = at_limit(hu, LIM_9);
        ht_l    = at_limit(ht, LIM_2);
        hr_wrap = ht_l && at_limit(hu, LIM_3);

        inc_d    = '0;
        zero_raw = {ht_l, hu_l || hr_wrap, mt_l, mu_l, st_l, su_l};
        sec_go   = 1'b0;
        min_go   = 1'b0;
        hr_go    = 1'b0;
        case (issue)
            REQ_TICK: sec_go = 1'b1;
            REQ_MIN:  min_go = 1'b1;
            REQ_HR:   hr_go  = 1'b1;
            REQ_SEC0: begin
                inc_d[SEC_U]    = 1'b1;
                inc_d[SEC_T]    = 1'b1;
                zero_raw[SEC_U] = 1'b1;
                zero_raw[SEC_T] = 1'b1;
            end
            default: ;
        endcase

        if (sec_go) begin
            inc_d[SEC_U] = 1'b1;
            inc_d[SEC_T] = su_l;
            min_go       = su_l && st_l;
        end
        // Minute adjust never carries into hours; only a running tick does.
        if (min_go) begin
            inc_d[MIN_U] = 1'b1;
            inc_d[MIN_T] = mu_l;
            if (sec_go && mu_l && mt_l) hr_go = 1'b1;
        end
        if (hr_go) begin
            inc_d[HR_U] = 1'b1;
            inc_d[HR_T] = hu_l || hr_wrap;
        end

        zero_d = zero_raw & inc_d;
        sec_d  = (issue == REQ_TICK);
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= RUN;
            presc_q <= '0;
            pend_q  <= REQ_NONE;
            inc_q   <= '0;
            zero_q  <= '0;
            sec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            pend_q  <= pend_d;
            inc_q   <= inc_d;
            zero_q  <= zero_d;
            sec_q   <= sec_d;
        end
    end

    assign increment = inc_q;
    assign zero      = zero_q;
    assign second    = sec_q;
    assign set_state = state_q;

endmodule

// File: tb/tb_time_sequencer.sv
// tb/tb_time_sequencer.sv - directed self-checking bench for time_sequencer with model digit registers
module tb_time_sequencer;

    localparam int CLK_HZ = 8;
    localparam int DEB    = 4;

    logic        clock    = 1'b0;
    logic        n_reset  = 1'b0;
    logic        mode_btn = 1'b0;
    logic        adv_btn  = 1'b0;
    logic        load_en  = 1'b0;
    logic [23:0] load_val = '0;
    logic [23:0] dig      = '0;
    logic [5:0]  increment, zero;
    logic        second;
    logic [1:0]  set_state;

    int n_tests = 0;
    int n_fail  = 0;
    int sec_cnt = 0;
    int snap    = 0;

    time_sequencer #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB)) dut (
        .clock     (clock),
        .n_reset   (n_reset),
        .digits    (dig),
        .mode_btn  (mode_btn),
        .adv_btn   (adv_btn),
        .increment (increment),
        .zero      (zero),
        .second    (second),
        .set_state (set_state)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (load_en) begin
            dig <= load_val;
        end else begin
            for (int i = 0; i < 6; i++)
                if (increment[i]) dig[i*4 +: 4] <= zero[i] ? 4'd0 : dig[i*4 +: 4] + 4'd1;
        end
    end

    always @(negedge clock) if (second) sec_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_second(input string tag);
        int n = 0;
        while (second !== 1'b1 && n < 40) begin step(); n++; end
        chk(tag, 32'(second), 1);
    endtask

    task automatic wait_strobe(input string tag);
        int n = 0;
        while (increment === 6'd0 && n < 40) begin step(); n++; end
        chk(tag, 32'(increment !== 6'd0), 1);
    endtask

    task automatic wait_state(input string tag, input logic [1:0] s);
        int n = 0;
        while (set_state !== s && n < 40) begin step(); n++; end
        chk(tag, 32'(set_state), 32'(s));
    endtask

    initial begin
        load_en  = 1'b1;
        load_val = 24'h000000;
        step();
        step();
        chk("rst_inc",   32'(increment), 0);
        chk("rst_zero",  32'(zero), 0);
        chk("rst_sec",   32'(second), 0);
        chk("rst_state", 32'(set_state), 0);
        n_reset = 1'b1;
        load_en = 1'b0;

        repeat (7) step();
        chk("pre_tick_sec", 32'(second), 0);
        step();
        chk("first_sec",  32'(second), 1);
        chk("first_inc",  32'(increment), 'b000001);
        chk("first_zero", 32'(zero), 0);
        step();
        chk("first_digits", 32'(dig), 'h000001);

        load_val = 24'h235959; load_en = 1'b1; step(); load_en = 1'b0;
        wait_second("wrap_wait");
        chk("wrap_inc",  32'(increment), 'b111111);
        chk("wrap_zero", 32'(zero), 'b111111);
        step();
        chk("wrap_digits", 32'(dig), 'h000000);

        load_val = 24'h095959; load_en = 1'b1; step(); load_en = 1'b0;
        wait_second("h09_wait");
        chk("h09_inc",  32'(increment), 'b111111);
        chk("h09_zero", 32'(zero), 'b011111);
        step();
        chk("h09_digits", 32'(dig), 'h100000);

        load_val = 24'h231542; load_en = 1'b1; step(); load_en = 1'b0;
        step();
        mode_btn = 1'b1;
        repeat (6) step();
        chk("mode_latency", 32'(set_state), 0);
        step();
        chk("enter_set_hr", 32'(set_state), 'b01);
        chk("set_hr_digits", 32'(dig), 'h231543);
        mode_btn = 1'b0;
        snap = sec_cnt;

        adv_btn = 1'b1;
        wait_strobe("hr_adv_wait");
        chk("hr_adv_inc",  32'(increment), 'b110000);
        chk("hr_adv_zero", 32'(zero), 'b110000);
        adv_btn = 1'b0;
        step();
        chk("hr_adv_digits", 32'(dig), 'h001543);

        mode_btn = 1'b1;
        wait_state("enter_set_min", 2'b10);
        mode_btn = 1'b0;
        load_val = 24'h005943; load_en = 1'b1; step(); load_en = 1'b0;
        adv_btn = 1'b1;
        wait_strobe("min_adv_wait");
        chk("min_adv_inc",  32'(increment), 'b001100);
        chk("min_adv_zero", 32'(zero), 'b001100);
        adv_btn = 1'b0;
        step();
        chk("min_adv_digits", 32'(dig), 'h000043);

        mode_btn = 1'b1;
        wait_strobe("to_run_wait");
        mode_btn = 1'b0;
        chk("to_run_inc",   32'(increment), 'b000011);
        chk("to_run_zero",  32'(zero), 'b000011);
        chk("to_run_state", 32'(set_state), 0);
        chk("to_run_sec",   32'(second), 0);
        chk("no_sec_in_set", 32'(sec_cnt), 32'(snap));
        step();
        chk("to_run_digits", 32'(dig), 'h000000);
        repeat (6) step();
        chk("resume_gap_sec", 32'(second), 0);
        step();
        chk("resume_sec", 32'(second), 1);
        chk("resume_inc", 32'(increment), 'b000001);

        step(); mode_btn = 1'b1;
        step(); adv_btn = 1'b1;
        repeat (6) step();
        chk("coinc_tick_inc", 32'(increment), 'b000001);
        chk("coinc_state",    32'(set_state), 'b01);
        step();
        chk("coinc_idle", 32'(increment), 0);
        step();
        chk("coinc_hr_inc",  32'(increment), 'b010000);
        chk("coinc_hr_zero", 32'(zero), 0);
        mode_btn = 1'b0;
        adv_btn  = 1'b0;
        step();
        chk("coinc_digits", 32'(dig), 'h010002);

        repeat (8) step();
        for (int g = 0; g < 3; g++) begin
            mode_btn = 1'b1; repeat (3) step();
            mode_btn = 1'b0; repeat (3) step();
        end
        repeat (8) step();
        chk("bounce_state", 32'(set_state), 'b01);

        adv_btn = 1'b1;
        wait_strobe("rst_adv_wait");
        chk("rst_adv_inc", 32'(increment), 'b010000);
        n_reset = 1'b0;
        #1;
        chk("midrst_inc",   32'(increment), 0);
        chk("midrst_zero",  32'(zero), 0);
        chk("midrst_sec",   32'(second), 0);
        chk("midrst_state", 32'(set_state), 0);
        adv_btn = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
